// File: rtl/mem_master_if.sv
// rtl/mem_master_if.sv - command, write, read, status and memory-side signals of mem_master
interface mem_master_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              mem_enable;
  logic              mem_read_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_data_in,
    output req_ready, wr_ready, rd_valid, rd_data, busy, done,
           mem_enable, mem_read_write, mem_address, mem_data_out
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, mem_data_in,
    input  req_ready, wr_ready, rd_valid, rd_data, busy, done,
           mem_enable, mem_read_write, mem_address, mem_data_out
  );
endinterface

// File: rtl/mem_master.sv
// rtl/mem_master.sv - burst master driving an async-style memory with setup/strobe/hold phases
module mem_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic          clk,
  input logic          resetn,
  mem_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD, DONE} state_t;

  state_t            state;
  logic              write_burst;
  logic [ADDR_W-1:0] beats_left;
  logic              mem_enable;
  logic              mem_read_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              wr_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      write_burst    <= 1'b0;
      beats_left     <= '0;
      mem_enable     <= 1'b0;
      mem_read_write <= 1'b1;
      mem_address    <= '0;
      mem_data_out   <= '0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      done           <= 1'b0;
      wr_ready       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_burst <= bus.req_write;
            mem_address <= bus.req_addr;
            beats_left  <= bus.req_len;
            if (bus.req_write) begin
              state    <= LOAD;
              wr_ready <= 1'b1;
            end else begin
              state <= SETUP;
            end
          end
        end
        LOAD: begin
          // Direction flips to write only once data is in hand, so a stall never looks like a write.
          if (bus.wr_valid) begin
            mem_data_out   <= bus.wr_data;
            mem_read_write <= 1'b0;
            wr_ready       <= 1'b0;
            state          <= SETUP;
          end
        end
        SETUP: begin
          mem_enable <= 1'b1;
          state      <= STROBE;
        end
        STROBE: begin
          mem_enable <= 1'b0;
          if (!write_burst) begin
            rd_data  <= bus.mem_data_in;
            rd_valid <= 1'b1;
          end
          state <= HOLD;
        end
        HOLD: begin
          mem_read_write <= 1'b1;
          if (beats_left == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            beats_left  <= beats_left - ADDR_W'(1);
            mem_address <= mem_address + ADDR_W'(1);
            if (write_burst) begin
              state    <= LOAD;
              wr_ready <= 1'b1;
            end else begin
              state <= SETUP;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = (state == IDLE) && resetn;
  assign bus.busy           = (state != IDLE);
  assign bus.wr_ready       = wr_ready;
  assign bus.rd_valid       = rd_valid;
  assign bus.rd_data        = rd_data;
  assign bus.done           = done;
  assign bus.mem_enable     = mem_enable;
  assign bus.mem_read_write = mem_read_write;
  assign bus.mem_address    = mem_address;
  assign bus.mem_data_out   = mem_data_out;
endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - randomized self-checking bench for mem_master against a word-level memory model
module tb_mem_master;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  mem_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DATA_W-1:0] mem [8];
  logic [DATA_W-1:0] ref_mem [8];
  logic [DATA_W-1:0] wbuf [8];
  logic mem_loaded = 1'b0;
  logic rst_edge = 1'b0;

  int                rd_cyc_q [$];
  logic [DATA_W-1:0] rd_dat_q [$];
  int                done_q [$];
  int                acc_q [$];
  int                en_addr_q [$];

  logic        prev_en = 1'b0;
  logic [19:0] prev_bus = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Environment memory: combinational read, write on an enabled edge with ReadWrite low.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !resetn;
    if (!mem_loaded) begin
      for (int i = 0; i < 8; i++) mem[i] <= DATA_W'(16'h3c00 ^ (i * 16'h1111));
      mem_loaded <= 1'b1;
    end else if (bus.mem_enable && !bus.mem_read_write) begin
      mem[bus.mem_address] <= bus.mem_data_out;
    end
  end
  assign bus.mem_data_in = mem[bus.mem_address];

  always @(negedge clk) begin
    if (bus.rd_valid) begin
      rd_cyc_q.push_back(cyc);
      rd_dat_q.push_back(bus.rd_data);
    end
    if (bus.done) done_q.push_back(cyc);
    if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
    if (bus.mem_enable) en_addr_q.push_back(int'(bus.mem_address));
    if (resetn && !rst_edge && (bus.mem_enable || prev_en))
      check("bus_stable", {bus.mem_address, bus.mem_read_write, bus.mem_data_out}, prev_bus);
    if (resetn && (bus.wr_ready || !bus.busy || bus.done))
      check("rw_high_idle", bus.mem_read_write, 1);
    prev_en  = bus.mem_enable;
    prev_bus = {bus.mem_address, bus.mem_read_write, bus.mem_data_out};
  end

  task automatic do_cmd(input bit wr, input int addr, input int len, input int stall);
    int t;
    int k;
    int st;
    int exp_done;
    rd_cyc_q.delete();
    rd_dat_q.delete();
    en_addr_q.delete();
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = ADDR_W'(addr);
    bus.req_len   = ADDR_W'(len);
    if (!wr) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = DATA_W'($urandom);
    end
    t = 0;
    while (!bus.req_ready && t < 50) begin tick(); t++; end
    check("req_ready_wait", bus.req_ready, 1);
    k = cyc;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = ADDR_W'($urandom);
    bus.req_len   = ADDR_W'($urandom);
    exp_done = k + 1;
    if (wr) begin
      for (int i = 0; i <= len; i++) begin
        st = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
        t = 0;
        while (!bus.wr_ready && t < 50) begin tick(); t++; end
        check("wr_ready_wait", bus.wr_ready, 1);
        repeat (st) begin
          check("load_stall", {bus.wr_ready, bus.mem_enable, bus.mem_read_write}, 3'b101);
          tick();
        end
        bus.wr_valid = 1'b1;
        bus.wr_data  = wbuf[i];
        ref_mem[(addr + i) % 8] = wbuf[i];
        tick();
        bus.wr_valid = 1'b0;
        exp_done += st + 4;
      end
    end else begin
      exp_done += 3 * (len + 1);
    end
    t = 0;
    while (!bus.done && t < 200) begin tick(); t++; end
    bus.wr_valid = 1'b0;
    check("done_seen", bus.done, 1);
    check("done_cycle", cyc, exp_done);
    tick();
    check("ready_after_done", bus.req_ready, 1);
    check("enable_pulses", en_addr_q.size(), len + 1);
    for (int i = 0; i <= len && i < en_addr_q.size(); i++)
      check("strobe_addr", en_addr_q[i], (addr + i) % 8);
    if (wr) begin
      check("wr_no_rdvalid", rd_cyc_q.size(), 0);
    end else begin
      check("rd_beats", rd_cyc_q.size(), len + 1);
      for (int i = 0; i <= len && i < rd_cyc_q.size(); i++) begin
        check("rd_cycle", rd_cyc_q[i], k + 3 + 3 * i);
        check("rd_data", rd_dat_q[i], ref_mem[(addr + i) % 8]);
      end
    end
  endtask

  initial begin
    int t;
    int k;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = DATA_W'(16'h3c00 ^ (i * 16'h1111));

    resetn = 1'b0;
    repeat (2) tick();
    check("rst_req_ready", bus.req_ready, 0);
    resetn = 1'b1;
    #1;
    check("release_req_ready", bus.req_ready, 1);
    tick();
    check("rst_mem_enable", bus.mem_enable, 0);
    check("rst_read_write", bus.mem_read_write, 1);
    check("rst_address", bus.mem_address, 0);
    check("rst_data_out", bus.mem_data_out, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready_after", bus.req_ready, 1);

    wbuf[0] = 16'hA5A5;
    do_cmd(1'b1, 2, 0, 0);
    do_cmd(1'b0, 2, 0, 0);

    for (int i = 0; i < 4; i++) wbuf[i] = DATA_W'(i + 1);
    do_cmd(1'b1, 6, 3, 0);
    do_cmd(1'b0, 6, 3, 0);

    for (int i = 0; i < 8; i++) wbuf[i] = DATA_W'($urandom);
    do_cmd(1'b1, 1, 2, 5);
    do_cmd(1'b0, 1, 2, 0);

    // Command held valid: second acceptance only in IDLE right after the first Done.
    done_q.delete();
    acc_q.delete();
    rd_cyc_q.delete();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 3'd3;
    bus.req_len   = 3'd1;
    t = 0;
    while (done_q.size() < 2 && t < 100) begin tick(); t++; end
    bus.req_valid = 1'b0;
    check("hold_dones", done_q.size(), 2);
    check("hold_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2 && done_q.size() == 2) begin
      check("hold_first_done", done_q[0], acc_q[0] + 7);
      check("hold_second_acc", acc_q[1], done_q[0] + 1);
    end
    check("hold_rd_beats", rd_cyc_q.size(), 4);
    tick();

    // Reset during STROBE of the second beat of an 8-beat read.
    rd_cyc_q.delete();
    done_q.delete();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 3'd0;
    bus.req_len   = 3'd7;
    t = 0;
    while (!bus.req_ready && t < 50) begin tick(); t++; end
    k = cyc;
    tick();
    bus.req_valid = 1'b0;
    t = 0;
    while (cyc < k + 5 && t < 50) begin tick(); t++; end
    check("beat2_strobe", bus.mem_enable, 1);
    resetn = 1'b0;
    tick();
    check("midrst_enable", bus.mem_enable, 0);
    check("midrst_busy", bus.busy, 0);
    resetn = 1'b1;
    repeat (20) tick();
    check("midrst_rd_beats", rd_cyc_q.size(), 1);
    check("midrst_no_done", done_q.size(), 0);
    do_cmd(1'b0, 0, 0, 0);

    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = DATA_W'($urandom);
      do_cmd(1'($urandom), int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), -1);
    end
    for (int a = 0; a < 8; a++) do_cmd(1'b0, a, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter DATA_W, 16, memory word width.
REQ-002 Parameter ADDR_W, 3, memory address width; the memory depth is 2**ADDR_W = 8 words.
REQ-003 Clock  input  1  single clock; all state changes on the rising edge.
REQ-004 ResetN  input  1  reset, synchronous and active-low.
REQ-005 ReqValid  input  1  the command is valid.
REQ-006 ReqReady  output  1  the block accepts a command this cycle.
REQ-007 ReqWrite  input  1  command type: 1 = write burst, 0 = read burst.
REQ-008 ReqAddr  input  ADDR_W  burst start address.
REQ-009 ReqLen  input  ADDR_W  burst length minus one (0..7, giving 1..8 beats).
REQ-010 WrValid  input  1  write beat data is valid.
REQ-011 WrReady  output  1  the block takes WrData this cycle.
REQ-012 WrData  input  DATA_W  write beat data.
REQ-013 RdValid  output  1  RdData holds one read beat.
REQ-014 RdData  output  DATA_W  read beat data.
REQ-015 Busy  output  1  a command is in progress (state is not IDLE).
REQ-016 Done  output  1  one-cycle pulse when a burst completes.
REQ-017 MemEnable  output  1  drives the memory Enable input.
REQ-018 MemReadWrite  output  1  drives the memory ReadWrite input: 1 = read, 0 = write.
REQ-019 MemAddress  output  ADDR_W  drives the memory Address input.
REQ-020 MemDataOut  output  DATA_W  drives the memory DataIn input.
REQ-021 MemDataIn  input  DATA_W  receives the memory DataOut output.

Function
REQ-022 The state machine SHALL have the states IDLE, LOAD, SETUP, STROBE, HOLD and DONE.
REQ-023 ReqReady SHALL be 1 only in IDLE; a command SHALL be accepted on the edge where ReqValid and ReqReady are both 1; at that edge the block latches ReqWrite, ReqAddr and ReqLen.
REQ-024 On acceptance, the next state SHALL be LOAD for a write and SETUP for a read.
REQ-025 LOAD: WrReady=1, MemEnable=0; the block waits while WrValid=0; on WrValid=1 it latches WrData into MemDataOut and moves to SETUP.
REQ-026 SETUP: MemEnable=0, with MemAddress and MemReadWrite (and MemDataOut for writes) driven stable; the block moves to STROBE after one cycle.
REQ-027 STROBE: MemEnable=1 for exactly one cycle; for reads, MemDataIn SHALL be registered into RdData at the edge leaving STROBE.
REQ-028 HOLD: MemEnable=0 while address and data stay unchanged; for reads, RdValid=1 for this one cycle.
REQ-029 Leaving HOLD with beats remaining: MemAddress increments modulo 8 (7 wraps to 0), and the next state is LOAD (write) or SETUP (read); with no beats remaining, the next state is DONE.
REQ-030 DONE SHALL assert Done=1 for one cycle, set MemReadWrite=1, and then return to IDLE.
REQ-031 MemAddress, MemReadWrite and MemDataOut SHALL never change in a cycle where MemEnable=1, nor on the edge that raises or lowers MemEnable.
REQ-032 In IDLE, LOAD and DONE, MemReadWrite SHALL be 1, so an idle or stalled bus can never cause a write.
REQ-033 Read beat timing: accept edge at cycle 0 -> SETUP in cycle 1 -> STROBE in cycle 2 -> RdValid in cycle 3; each later beat adds 3 cycles.
REQ-034 Single-read latency: Done in cycle 4, ReqReady=1 again in cycle 5.
REQ-035 Write beats SHALL take 3 cycles plus the LOAD wait, with a minimum of 1 LOAD cycle per beat.
REQ-036 ReqValid SHALL be ignored outside IDLE, including in the DONE cycle.
REQ-037 WrValid SHALL be ignored outside LOAD, and WrReady SHALL be 0 outside LOAD.
REQ-038 RdValid SHALL never assert during a write burst.
REQ-039 MemEnable, RdValid, Done and WrReady SHALL be registered or decoded directly from state registers, with no combinational path from any input.

Reset
REQ-040 While ResetN=0 at a rising edge, the block SHALL enter IDLE; reset overrides any other transition.
REQ-041 Reset values: MemEnable=0, MemReadWrite=1, MemAddress=0, MemDataOut=0, RdData=0, RdValid=0, Done=0, WrReady=0, Busy=0.
REQ-042 ReqReady SHALL be 0 while ResetN=0 and 1 in the first cycle after ResetN returns to 1.
REQ-043 Reset asserted mid-burst SHALL drop MemEnable to 0 at that edge; the burst is abandoned, and no Done or further RdValid is issued.

Verification
REQ-044 Run with ResetN=0 for 2 cycles, then release -> all outputs equal their REQ-041 values, and ReqReady=1 in the first cycle after release.
REQ-045 Write ReqAddr=2, ReqLen=0, WrData=16'hA5A5, then read ReqAddr=2, ReqLen=0 -> one MemEnable pulse per command; RdValid with RdData=16'hA5A5 in cycle 3 after read acceptance; Done in cycle 4.
REQ-046 Write burst ReqAddr=6, ReqLen=3 with data 1,2,3,4, then read burst ReqAddr=6, ReqLen=3 -> MemAddress sequence 6,7,0,1 with wrap; RdData sequence 1,2,3,4 at 3-cycle spacing; exactly 4 RdValid pulses.
REQ-047 Write burst with WrValid held 0 for 5 cycles before each beat -> state stays in LOAD, MemEnable=0, MemReadWrite=1 throughout the stall; data still lands correctly.
REQ-048 ReqValid=1 held continuously across a burst -> the second command is accepted only in IDLE after Done, never in DONE or mid-burst.
REQ-049 ResetN=0 applied during STROBE of beat 2 of an 8-beat read -> MemEnable=0 after that edge, no further RdValid, no Done; a following single read completes normally.
